// File: rtl/enigma_pkg.sv
// Shared definitions for the Enigma front-panel input path: debouncer state encoding and
// default qualification length.
package enigma_pkg;

  typedef enum logic [1:0] {
    StLow      = 2'b00,
    StPendHigh = 2'b01,
    StHigh     = 2'b11,
    StPendLow  = 2'b10
  } key_state_e;

  // 10 ms at 50 MHz
  localparam int unsigned StableCyclesDefault = 500000;

  function automatic logic is_pending(key_state_e st);
    return (st == StPendHigh) || (st == StPendLow);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debouncer channel: optional two-flop synchroniser (KEY_DEBOUNCE_SYNC_EN), then a
// four-state qualification FSM with a stability counter and registered level/pending flags.
module debounce_channel
  import enigma_pkg::*;
#(
  parameter int unsigned StableCycles = StableCyclesDefault,
  parameter int unsigned CntW         = $clog2(StableCycles)
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic key_i,
  output logic level_o,
  output logic pend_o
);

  localparam logic [CntW-1:0] CntMax = CntW'(StableCycles - 1);

  logic            s;
  key_state_e      state_q;
  logic [CntW-1:0] cnt_q;
  logic            level_q;
  logic            pend_q;

`ifdef KEY_DEBOUNCE_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], key_i};
    end
  end

  assign s = sync_q[1];
`else
  assign s = key_i;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StLow;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StLow: begin
          if (s) begin
            state_q <= StPendHigh;
            cnt_q   <= '0;
            pend_q  <= 1'b1;
          end
        end
        StPendHigh: begin
          if (!s) begin
            state_q <= StLow;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
          end else if (cnt_q == CntMax) begin
            state_q <= StHigh;
            cnt_q   <= '0;
            level_q <= 1'b1;
            pend_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StHigh: begin
          if (!s) begin
            state_q <= StPendLow;
            cnt_q   <= '0;
            pend_q  <= 1'b1;
          end
        end
        StPendLow: begin
          if (s) begin
            state_q <= StHigh;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
          end else if (cnt_q == CntMax) begin
            state_q <= StLow;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pend_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: begin
          state_q <= StLow;
          cnt_q   <= '0;
          level_q <= 1'b0;
          pend_q  <= 1'b0;
        end
      endcase
    end
  end

  assign level_o = level_q;
  assign pend_o  = pend_q;

endmodule

// File: rtl/key_debouncer.sv
// Multi-channel push-button debouncer; N_KEYS independent debounce_channel instances.
// Build option: define KEY_DEBOUNCE_SYNC_EN to add a two-flop synchroniser per input.
module key_debouncer
  import enigma_pkg::*;
#(
  parameter int unsigned N_KEYS        = 4,
  parameter int unsigned STABLE_CYCLES = StableCyclesDefault
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] keys_raw,
  output logic [N_KEYS-1:0] keys_level,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);

  logic [N_KEYS-1:0] pend;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    debounce_channel #(
      .StableCycles(STABLE_CYCLES),
      .CntW        (CNT_W)
    ) u_ch (
      .clk_i  (clk),
      .reset_i(reset),
      .key_i  (keys_raw[i]),
      .level_o(keys_level[i]),
      .pend_o (pend[i])
    );
  end

  // Pending flags are registered per channel, so busy tracks the state registers directly.
  assign busy = |pend;

endmodule
